// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with parking, locked tenures and a per-tenure
// beat limit. Grant is registered; ownership (o_hmaster) follows the grant on
// the next HREADY edge, and o_hmaster_d tracks the data-phase owner.
module ahb_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16,
    localparam int MW            = $clog2(N_MASTERS)
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset,
    input  logic [N_MASTERS-1:0] i_hbusreq,
    input  logic [N_MASTERS-1:0] i_hlock,
    input  logic [1:0]           i_htrans,
    input  logic                 i_hready,
    output logic [N_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]        o_hmaster,
    output logic [MW-1:0]        o_hmaster_d,
    output logic                 o_hmastlock
);

    localparam int              CW      = $clog2(MAX_BEATS + 1);
    localparam logic [CW:0]     LIMIT   = (CW+1)'(MAX_BEATS);
    localparam logic [MW-1:0]   DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [MW-1:0]          gidx_q, gidx_d;       // index of the granted master
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          hmaster_dph_q, hmaster_dph_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   found;
    logic [MW-1:0]          win;
    logic [MW-1:0]          cand;
    logic [CW:0]            cnt_sum;
    logic                   limit_hit;
    logic                   handed;
    logic                   owner_req, owner_lock;
    logic                   arb;

    // Round-robin search starting just above the address-phase owner, so the
    // owner itself is visited last.
    always_comb begin
        found = 1'b0;
        win   = DEF_IDX;
        cand  = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = MW'((int'(hmaster_q) + i) % N_MASTERS);
            if (!found && i_hbusreq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Arbitration decision and next-state for grant, ownership, lock and beat count.
    always_comb begin
        // NONSEQ/SEQ both have htrans[1] set; IDLE/BUSY do not count.
        cnt_sum    = {1'b0, cnt_q} + {{CW{1'b0}}, i_htrans[1]};
        limit_hit  = (cnt_sum >= LIMIT);
        // The limit only applies once the granted master actually owns the
        // address phase; otherwise the previous owner's count would re-trigger.
        handed     = (gidx_q == hmaster_q);
        owner_req  = i_hbusreq[gidx_q];
        owner_lock = i_hlock[gidx_q];

        if (state_q == LOCK)
            arb = i_hready && !owner_lock;
        else
            arb = i_hready && ((state_q == PARK) || !owner_req || (handed && limit_hit));

        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        hmaster_d     = hmaster_q;
        hmaster_dph_d = hmaster_dph_q;
        hmastlock_d   = hmastlock_q;
        cnt_d         = cnt_q;

        if (i_hready) begin
            hmaster_d     = gidx_q;
            hmaster_dph_d = hmaster_q;
            // Lock becomes visible with the handover and drops on the exit edge.
            hmastlock_d   = (state_q == LOCK) && owner_lock;

            if ((gidx_q != hmaster_q) || (arb && (win == hmaster_q)))
                cnt_d = '0;
            else if (limit_hit)
                cnt_d = LIMIT[CW-1:0];
            else
                cnt_d = cnt_sum[CW-1:0];

            if (arb) begin
                gidx_d  = win;
                grant_d = ONE << win;
                if (!found)
                    state_d = PARK;
                else if (i_hlock[win])
                    state_d = LOCK;
                else
                    state_d = OWN;
            end
        end
    end

    // State registers; reset overrides everything including a locked tenure.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q       <= PARK;
            grant_q       <= ONE << DEF_IDX;
            gidx_q        <= DEF_IDX;
            hmaster_q     <= DEF_IDX;
            hmaster_dph_q <= DEF_IDX;
            hmastlock_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            hmaster_q     <= hmaster_d;
            hmaster_dph_q <= hmaster_dph_d;
            hmastlock_q   <= hmastlock_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_hgrant    = grant_q;
    assign o_hmaster   = hmaster_q;
    assign o_hmaster_d = hmaster_dph_q;
    assign o_hmastlock = hmastlock_q;

endmodule
